// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT/BTB branch predictor with in-flight prediction queue
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int PQ_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        pred_taken,
  output logic [31:0] pred_dst,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_src,
  input  logic [31:0] resolve_dst,
  input  logic        resolve_taken,
  output logic        resolve_right
);

  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int TAG_W  = 30 - BTB_IW;
  localparam int PW     = $clog2(PQ_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [1:0]       bht        [BHT_ENTRIES];
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];

  logic [31:0] q_src   [PQ_DEPTH];
  logic [31:0] q_dst   [PQ_DEPTH];
  logic        q_taken [PQ_DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [PW:0] head;
  logic [PW:0] tail;

  logic [BHT_IW-1:0] fetch_bht_idx;
  logic [BTB_IW-1:0] fetch_btb_idx;
  logic [BHT_IW-1:0] res_bht_idx;
  logic [BTB_IW-1:0] res_btb_idx;
  logic [PW-1:0]     head_idx;
  logic [PW-1:0]     tail_idx;
  logic              empty;
  logic              full;
  logic              pop;
  logic              flush;
  logic              push;

  assign fetch_bht_idx = fetch_pc[BHT_IW+1:2];
  assign fetch_btb_idx = fetch_pc[BTB_IW+1:2];
  assign res_bht_idx   = resolve_src[BHT_IW+1:2];
  assign res_btb_idx   = resolve_src[BTB_IW+1:2];
  assign head_idx      = head[PW-1:0];
  assign tail_idx      = tail[PW-1:0];

  assign empty = (head == tail);
  assign full  = (head[PW] != tail[PW]) && (head_idx == tail_idx);

  // Fetch-side lookup reads the tables as they stand before this cycle's update.
  always_comb begin
    pred_taken = btb_valid[fetch_btb_idx]
              && (btb_tag[fetch_btb_idx] == fetch_pc[31:BTB_IW+2])
              && bht[fetch_bht_idx][1];
    pred_dst   = pred_taken ? btb_target[fetch_btb_idx] : fetch_pc + 32'd4;
  end

  // Compare the resolving branch against the oldest outstanding prediction.
  always_comb begin
    resolve_right = resolve_valid && !empty
                 && (q_src[head_idx] == resolve_src)
                 && (q_taken[head_idx] == resolve_taken)
                 && (!resolve_taken || (q_dst[head_idx] == resolve_dst));
  end

  // A correct resolve frees the head slot, so a full queue can still take a push that cycle.
  assign fetch_ready = !full;
  assign pop   = resolve_valid && resolve_right;
  assign flush = resolve_valid && !resolve_right;
  assign push  = fetch_valid && !flush && (fetch_ready || pop);

  // Queue pointers: mispredict flushes by collapsing head onto tail.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= tail;
    end else begin
      if (pop)  head <= head + PTR_ONE;
      if (push) tail <= tail + PTR_ONE;
    end
  end

  // Queue payload written at the tail slot on every accepted push.
  always_ff @(posedge clock) begin
    if (push) begin
      q_src[tail_idx]   <= fetch_pc;
      q_taken[tail_idx] <= pred_taken;
      q_dst[tail_idx]   <= pred_dst;
    end
  end

  // Train direction counters on every resolve; taken resolves also install the target.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'd1;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (bht[res_bht_idx] != 2'd3) bht[res_bht_idx] <= bht[res_bht_idx] + 2'd1;
        btb_valid[res_btb_idx]  <= 1'b1;
        btb_tag[res_btb_idx]    <= resolve_src[31:BTB_IW+2];
        btb_target[res_btb_idx] <= resolve_dst;
      end else if (bht[res_bht_idx] != 2'd0) begin
        bht[res_bht_idx] <= bht[res_bht_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready;
  logic        pred_taken;
  logic [31:0] pred_dst;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_src = '0;
  logic [31:0] resolve_dst = '0;
  logic        resolve_taken = 1'b0;
  logic        resolve_right;

  branch_predictor #(.BHT_ENTRIES(64), .BTB_ENTRIES(16), .PQ_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .pred_taken(pred_taken), .pred_dst(pred_dst),
    .resolve_valid(resolve_valid), .resolve_src(resolve_src), .resolve_dst(resolve_dst),
    .resolve_taken(resolve_taken), .resolve_right(resolve_right)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counters as plain integers, target buffer as arrays, queue as a SV queue.
  typedef struct { logic [31:0] src; logic taken; logic [31:0] dst; } ent_t;
  ent_t        mq[$];
  int          m_bht [64];
  bit          m_bv  [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];

  logic        obs_taken, obs_ready, obs_right, exp_taken, exp_ready, exp_right;
  logic [31:0] obs_dst, exp_dst;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic t, output logic [31:0] d);
    int bi = int'(pc[7:2]);
    int ti = int'(pc[5:2]);
    t = m_bv[ti] && (m_tag[ti] == pc[31:6]) && (m_bht[bi] >= 2);
    d = t ? m_tgt[ti] : pc + 32'd4;
  endfunction

  function automatic logic model_right(input logic rv, input logic [31:0] rs, rd, input logic rt);
    if (!rv || mq.size() == 0) return 1'b0;
    return (mq[0].src == rs) && (mq[0].taken == rt) && (!rt || mq[0].dst == rd);
  endfunction

  // Drive one cycle from a negedge, sample outputs 1ns later, then advance the model at the edge.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic rv,
                      input logic [31:0] rs, input logic [31:0] rd, input logic rt);
    bit pop, flush, push;
    fetch_valid = fv; fetch_pc = fpc;
    resolve_valid = rv; resolve_src = rs; resolve_dst = rd; resolve_taken = rt;
    #1;
    obs_taken = pred_taken; obs_dst = pred_dst; obs_ready = fetch_ready; obs_right = resolve_right;
    model_predict(fpc, exp_taken, exp_dst);
    exp_ready = (mq.size() < 8);
    exp_right = model_right(rv, rs, rd, rt);
    @(posedge clock);
    pop   = rv && exp_right;
    flush = rv && !exp_right;
    push  = fv && !flush && (mq.size() < 8 || pop);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{fpc, exp_taken, exp_dst});
    end
    if (rv) begin
      int bi = int'(rs[7:2]);
      int ti = int'(rs[5:2]);
      if (rt) begin
        m_bht[bi] = (m_bht[bi] == 3) ? 3 : m_bht[bi] + 1;
        m_bv[ti] = 1; m_tag[ti] = rs[31:6]; m_tgt[ti] = rd;
      end else begin
        m_bht[bi] = (m_bht[bi] == 0) ? 0 : m_bht[bi] - 1;
      end
    end
    @(negedge clock);
    fetch_valid = 1'b0; resolve_valid = 1'b0;
  endtask

  task automatic do_reset();
    fetch_valid = 1'b0; resolve_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    fetch_valid = 1'b0; fetch_pc = 32'h0000_1000; resolve_valid = 1'b1; resolve_src = 32'h1000;
    reset = 1'b1;
    #1;
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready actual=%0b required=1", fetch_ready); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken actual=%0b required=0", pred_taken); end
    n_cmp++; if (pred_dst !== 32'h1004) begin n_fail++; $display("FAIL reset_dst actual=%h required=00001004", pred_dst); end
    n_cmp++; if (resolve_right !== 1'b0) begin n_fail++; $display("FAIL reset_right actual=%0b required=0", resolve_right); end
    do_reset();
    step(1'b0, 32'hFFFF_FFFC, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_dst !== 32'h0) begin n_fail++; $display("FAIL wrap_dst actual=%h required=00000000", obs_dst); end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 32'h1000, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_taken !== 1'b0) begin n_fail++; $display("FAIL basic_taken actual=%0b required=0", obs_taken); end
    n_cmp++; if (obs_dst !== 32'h1004) begin n_fail++; $display("FAIL basic_dst actual=%h required=00001004", obs_dst); end
    step(1'b0, 0, 1'b1, 32'h1000, 32'h0, 1'b0);
    n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL basic_right actual=%0b required=1", obs_right); end
    step(1'b0, 0, 1'b1, 32'h1000, 32'h0, 1'b0);
    n_cmp++; if (obs_right !== 1'b0) begin n_fail++; $display("FAIL empty_right actual=%0b required=0", obs_right); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL empty_ready actual=%0b required=1", obs_ready); end
    step(1'b1, 32'h1100, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 32'h1100, 32'h0, 1'b0);
    n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL after_empty_right actual=%0b required=1", obs_right); end
  endtask

  task automatic test_mispredict();
    do_reset();
    step(1'b1, 32'h1000, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 32'h1000, 32'h2000, 1'b1);
    n_cmp++; if (obs_right !== 1'b0) begin n_fail++; $display("FAIL mis_right actual=%0b required=0", obs_right); end
    step(1'b1, 32'h1000, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_taken !== 1'b1) begin n_fail++; $display("FAIL mis_taken actual=%0b required=1", obs_taken); end
    n_cmp++; if (obs_dst !== 32'h2000) begin n_fail++; $display("FAIL mis_dst actual=%h required=00002000", obs_dst); end
    step(1'b0, 0, 1'b1, 32'h1000, 32'h2000, 1'b1);
    n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL mis_flushed_right actual=%0b required=1", obs_right); end
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 0, 0, 1'b0);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] actual=%0b required=1", i, obs_ready); end
    end
    step(1'b1, 32'h4000, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready actual=%0b required=0", obs_ready); end
    step(1'b1, 32'h5000, 1'b1, 32'h3000, 32'h0, 1'b0);
    n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL full_pop_right actual=%0b required=1", obs_right); end
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 0, 1'b1, 32'h3000 + 32'(i * 4), 32'h0, 1'b0);
      if (i == 1) begin
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL still_full_ready actual=%0b required=0", obs_ready); end
      end
      n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL drain_right[%0d] actual=%0b required=1", i, obs_right); end
    end
    step(1'b0, 0, 1'b1, 32'h5000, 32'h0, 1'b0);
    n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL drain_last_right actual=%0b required=1", obs_right); end
    step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL drained_ready actual=%0b required=1", obs_ready); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 32'h6040, 32'h7000, 1'b1);
    step(1'b0, 0, 1'b1, 32'h6040, 32'h0, 1'b0);
    step(1'b1, 32'h6040, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_taken !== 1'b1) begin n_fail++; $display("FAIL sat_taken actual=%0b required=1", obs_taken); end
    n_cmp++; if (obs_dst !== 32'h7000) begin n_fail++; $display("FAIL sat_dst actual=%h required=00007000", obs_dst); end
    step(1'b0, 0, 1'b1, 32'h6040, 32'h0, 1'b0);
    step(1'b1, 32'h6040, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_taken actual=%0b required=0", obs_taken); end
    n_cmp++; if (obs_dst !== 32'h6044) begin n_fail++; $display("FAIL sat_low_dst actual=%h required=00006044", obs_dst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 0, 1'b1, 32'h8080, 32'h9000, 1'b1);
    step(1'b0, 0, 1'b1, 32'h8080, 32'h9000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h8080, 1'b0, 0, 0, 1'b0);
    fetch_pc = 32'h8080;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready actual=%0b required=1", fetch_ready); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_taken actual=%0b required=0", pred_taken); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    step(1'b1, 32'h8080, 1'b0, 0, 0, 1'b0);
    n_cmp++; if (obs_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_fetch_taken actual=%0b required=0", obs_taken); end
    step(1'b0, 0, 1'b1, 32'h8080, 32'h0, 1'b0);
    n_cmp++; if (obs_right !== 1'b1) begin n_fail++; $display("FAIL midrst_single_right actual=%0b required=1", obs_right); end
  endtask

  task automatic test_random();
    logic        fv, rv, rt;
    logic [31:0] fpc, rs, rd;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      fv  = ($urandom_range(0, 3) != 0);
      fpc = 32'h0001_0000 | (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 15)) << 2);
      rv  = ($urandom_range(0, 1) == 1);
      rd  = 32'h0002_0000 + (32'($urandom_range(0, 3)) << 2);
      if (rv && mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        rs = mq[0].src; rt = mq[0].taken;
        if (rt) rd = mq[0].dst;
      end else begin
        rs = 32'h0001_0000 | (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 15)) << 2);
        rt = $urandom_range(0, 1) == 1;
      end
      step(fv, fpc, rv, rs, rd, rt);
      n_cmp++; if (obs_taken !== exp_taken) begin n_fail++; $display("FAIL rnd_taken[%0d] actual=%0b required=%0b", n, obs_taken, exp_taken); end
      n_cmp++; if (obs_dst !== exp_dst) begin n_fail++; $display("FAIL rnd_dst[%0d] actual=%h required=%h", n, obs_dst, exp_dst); end
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d] actual=%0b required=%0b", n, obs_ready, exp_ready); end
      n_cmp++; if (obs_right !== exp_right) begin n_fail++; $display("FAIL rnd_right[%0d] actual=%0b required=%0b", n, obs_right, exp_right); end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    test_reset();
    test_basic();
    test_mispredict();
    test_back_to_back_full();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
